// File: rtl/gfx_line_scheduler.sv
// Line-command scheduler for the Bresenham renderer: queues draw commands,
// issues them one at a time and shares the framebuffer with the display reader.
module gfx_line_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [7:0]         cmd_x0,
  input  logic signed [7:0]         cmd_y0,
  input  logic signed [7:0]         cmd_x1,
  input  logic signed [7:0]         cmd_y1,
  input  logic                      cmd_erase,
  output logic signed [7:0]         gfx_x0,
  output logic signed [7:0]         gfx_y0,
  output logic signed [7:0]         gfx_x1,
  output logic signed [7:0]         gfx_y1,
  output logic                      gfx_and_fb,
  output logic                      gfx_render,
  input  logic                      gfx_ready,
  input  logic                      gfx_done,
  output logic                      gfx_rd,
  input  logic                      refresh_req,
  output logic                      refresh_gnt,
  input  logic                      refresh_done,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_W-1:0]          lines_drawn
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GRANT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [32:0]       mem_q [DEPTH];
  logic [32:0]       gfx_q, gfx_d;
  logic              render_q, render_d;
  logic              last_ref_q, last_ref_d;
  logic [CNT_W-1:0]  lines_q, lines_d;

  logic              push;
  logic              pop;
  logic              empty;
  logic              ref_win;
  logic              rend_win;
  logic [32:0]       head;

  assign empty     = (level_q == '0);
  assign cmd_ready = (level_q != LW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  // Refresh yields to a pending line only right after it has just been served,
  // which gives strict alternation when both sides keep asking.
  assign ref_win  = refresh_req & (empty | ~last_ref_q);
  assign rend_win = ~ref_win & ~empty & gfx_ready;

  always_comb begin
    state_d    = state_q;
    last_ref_d = last_ref_q;
    lines_d    = lines_q;
    render_d   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ref_win) begin
          state_d = S_GRANT;
        end else if (rend_win) begin
          pop      = 1'b1;
          render_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gfx_done) begin
          lines_d    = lines_q + CNT_W'(1);
          last_ref_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_GRANT: begin
        if (refresh_done) begin
          last_ref_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    // The active command is only replaced on a pop, so it holds through WAIT.
    gfx_d = pop ? head : gfx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      gfx_q      <= '0;
      render_q   <= 1'b0;
      last_ref_q <= 1'b0;
      lines_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      gfx_q      <= gfx_d;
      render_q   <= render_d;
      last_ref_q <= last_ref_d;
      lines_q    <= lines_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_erase, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
    end
  end

  assign gfx_and_fb  = gfx_q[32];
  assign gfx_x0      = gfx_q[31:24];
  assign gfx_y0      = gfx_q[23:16];
  assign gfx_x1      = gfx_q[15:8];
  assign gfx_y1      = gfx_q[7:0];
  assign gfx_render  = render_q;
  assign refresh_gnt = (state_q == S_GRANT);
  assign gfx_rd      = refresh_gnt;
  assign busy        = (state_q != S_IDLE) | ~empty;
  assign level       = level_q;
  assign lines_drawn = lines_q;

endmodule

// File: doc/gfx_line_scheduler.md
# gfx_line_scheduler

Command scheduler in front of `gfx_unit_bresenham`. It queues line-draw commands in a small FIFO, issues them one at a time to the Bresenham renderer and holds each command stable until the renderer reports done. It also arbitrates the shared 128x64 framebuffer between line rendering and the SSD1306 refresh reader, so that a display readout never overlaps a line draw.

## Interface
- `DEPTH`, 8: command FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of `lines_drawn`.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset. The renderer's `resetn` is driven as `~reset`.
- `cmd_valid`  in  1  a command is offered on `cmd_*`.
- `cmd_ready`  out  1  FIFO not full; a transfer occurs on `cmd_valid & cmd_ready` at a rising edge.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1`  in  8 each, signed  line endpoints.
- `cmd_erase`  in  1  1 = clear pixels (AND mode), 0 = set pixels (OR mode).
- `gfx_x0`, `gfx_y0`, `gfx_x1`, `gfx_y1`  out  8 each  active command, registered, to the renderer.
- `gfx_and_fb`  out  1  active command erase flag.
- `gfx_render`  out  1  one-cycle render strobe, registered.
- `gfx_ready`  in  1  renderer idle.
- `gfx_done`  in  1  renderer one-cycle completion pulse.
- `gfx_rd`  out  1  framebuffer read-port select for the display path; equals `refresh_gnt`.
- `refresh_req`  in  1  display refresh wants the framebuffer; level, held until granted.
- `refresh_gnt`  out  1  framebuffer owned by the display reader.
- `refresh_done`  in  1  one-cycle pulse: display readout finished.
- `busy`  out  1  state is not IDLE, or the FIFO is not empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `lines_drawn`  out  CNT_W  count of completed lines; wraps modulo 2^CNT_W.

## Operation
- FIFO entries are 33 bits: {erase, x0, y0, x1, y1}. Writes happen on `cmd_valid & cmd_ready`. The FIFO has no fall-through: a pop only reads an entry present at the start of the cycle. Push and pop may occur in the same cycle; `level` is unchanged in that case.
- `cmd_ready = (level != DEPTH)`. While full, `cmd_valid` is ignored and nothing is dropped.
- FSM states: IDLE, ISSUE, WAIT, GRANT.
  - IDLE: evaluate arbitration (below). A render win loads the head entry into the `gfx_*` registers, pops the FIFO and moves to ISSUE. A refresh win moves to GRANT.
  - ISSUE: `gfx_render` = 1 for exactly this cycle; move to WAIT.
  - WAIT: `gfx_render` = 0. On `gfx_done`, increment `lines_drawn`, clear `last_ref` and return to IDLE.
  - GRANT: `refresh_gnt` = `gfx_rd` = 1. On `refresh_done`, set `last_ref`, return to IDLE; grant deasserts in the following cycle.
- Arbitration in IDLE:
  - Refresh wins if `refresh_req` and (FIFO empty or `last_ref` = 0).
  - Otherwise render wins if the FIFO is non-empty and `gfx_ready` = 1.
  - Otherwise stay in IDLE.
  - Result: strict alternation while both sides are pending; neither side starves.
- The `gfx_*` coordinate and mode outputs hold their value from the load until the next load. The renderer samples `x1`/`y1` on every step, so these outputs must not change during WAIT.
- Refresh is never granted in ISSUE or WAIT. A render is never issued in GRANT.
- `gfx_done` or `refresh_done` arriving in an unrelated state is ignored.

## Timing
- Reset values: `cmd_ready` = 1; `level` = 0; `gfx_render` = 0; `refresh_gnt` = `gfx_rd` = 0; `busy` = 0; `lines_drawn` = 0; `gfx_x0`..`gfx_y1` = 0; `gfx_and_fb` = 0; `last_ref` = 0; state = IDLE. The FIFO is emptied.
- Reset mid-draw or mid-grant: FSM and FIFO return to IDLE/empty in the next cycle. Queued commands are discarded and the grant drops.
- Latency, with an empty system: a command accepted at edge T leads to IDLE popping at edge T+1, then `gfx_render` = 1 during cycle T+2. The renderer sees the rising edge that cycle.
- Between consecutive renders, `gfx_render` is low for at least one cycle (WAIT, then IDLE). This satisfies the renderer's edge detector.
- From `gfx_done` to the next ISSUE is a minimum of 2 cycles (IDLE, then ISSUE).
- From `refresh_req` to `refresh_gnt`: 1 cycle when IDLE and the request wins. Otherwise the wait is bounded by one line draw plus 1 cycle.

## Test plan
- Single line: push (0,0)->(127,63) with erase 0. Check `gfx_render` high exactly one cycle, 2 cycles after acceptance, with `gfx_*` = 0,0,127,63. After `gfx_done`: `lines_drawn` = 1, `busy` = 0.
- Fill and back-pressure: with `gfx_ready` held 0, push 10 commands at DEPTH = 8. Check `cmd_ready` drops after 8 and `level` = 8. Release `gfx_ready`; all 8 draw in FIFO order; `lines_drawn` = 8.
- Fairness: hold `refresh_req` = 1 with 3 queued commands. Required grant order: refresh, line, refresh, line, refresh, line. `refresh_gnt` and `gfx_render` are never both high, and the grant is never high during WAIT.
- Stability: during a 200-cycle WAIT, push new commands every cycle. Check `gfx_x0`..`gfx_y1` and `gfx_and_fb` do not change until the next ISSUE.
- Spurious pulses: `gfx_done` asserted in IDLE, or `refresh_done` asserted in WAIT, cause no state change and no counter increment.
- Reset mid-WAIT with 4 entries queued: next cycle `level` = 0, `refresh_gnt` = 0, `gfx_render` = 0, `lines_drawn` = 0, `cmd_ready` = 1.
